// File: rtl/epu_seq_pkg.sv
// Shared definitions for the EPU layer sequencer: FSM state codes, descriptor
// field positions, operator encodings and error codes.
package epu_seq_pkg;

  // Operator encodings driven onto the conv bus switcher mode select
  localparam logic [3:0] IDLE_MODE     = 4'd0;
  localparam logic [3:0] CONV_3x3_MODE = 4'd1;
  localparam logic [3:0] CONV_1x1_MODE = 4'd2;
  localparam logic [3:0] MAX_POOL_MODE = 4'd3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_SWITCH = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  localparam int DESC_OP_LSB   = 0;
  localparam int DESC_OP_W     = 4;
  localparam int DESC_LAST_BIT = 31;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_OPCODE = 2'd1,
    ERR_WDOG   = 2'd2,
    ERR_LIMIT  = 2'd3
  } err_code_e;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op == CONV_3x3_MODE) || (op == CONV_1x1_MODE) || (op == MAX_POOL_MODE);
  endfunction

endpackage

// File: rtl/epu_layer_sequencer_if.sv
// Descriptor SRAM read port plus the operator-unit handshake seen by the sequencer.
interface epu_layer_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              desc_cs;
  logic              desc_oe;
  logic [ADDR_W-1:0] desc_addr;
  logic [31:0]       desc_R_data;
  logic [3:0]        mode;
  logic              unit_start;
  logic              unit_done;

  modport master (
    output desc_cs, desc_oe, desc_addr, mode, unit_start,
    input  desc_R_data, unit_done
  );

  modport slave (
    input  desc_cs, desc_oe, desc_addr, mode, unit_start,
    output desc_R_data, unit_done
  );
endinterface

// File: rtl/epu_layer_sequencer_watchdog.sv
// Run-time watchdog: counts enabled cycles and flags the cycle in which the
// count reaches all-ones.
module epu_watchdog #(
  parameter int WDOG_W = 24
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic en,
  output logic expire
);
  localparam logic [WDOG_W-1:0] PRE_EXPIRE = {{(WDOG_W-1){1'b1}}, 1'b0};

  logic [WDOG_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (en && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // The enabled cycle that would bring the count to all-ones is the timeout
  assign expire = en && (count_reg == PRE_EXPIRE);

endmodule

// File: rtl/epu_layer_sequencer.sv
// Layer-level controller: fetches one descriptor per layer, drives the conv bus
// switcher mode, launches the selected unit and stops on last/limit/error.
module epu_layer_sequencer
  import epu_seq_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int MAX_LAYERS = 64,
  parameter int WDOG_W     = 24,
  localparam int IDX_W     = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  epu_layer_sequencer_if.master   bus,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [1:0]              err_code,
  output logic [IDX_W-1:0]        layer_idx
);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_LAYERS - 1);

  logic [2:0]        state_reg, state_next;
  logic [ADDR_W-1:0] base_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic              last_reg;
  logic [3:0]        mode_reg;
  logic              unit_start_reg;
  logic              err_reg;
  err_code_e         err_code_reg, err_code_next;
  logic [3:0]        desc_op;
  logic              wdog_expire;
  logic              unused_desc_bits;

  assign desc_op          = bus.desc_R_data[DESC_OP_LSB +: DESC_OP_W];
  assign unused_desc_bits = ^bus.desc_R_data[DESC_LAST_BIT-1:DESC_OP_LSB+DESC_OP_W];

  epu_watchdog #(
    .WDOG_W (WDOG_W)
  ) u_watchdog (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (state_reg == S_SWITCH),
    .en     (state_reg == S_RUN),
    .expire (wdog_expire)
  );

  always_comb begin
    state_next    = state_reg;
    err_code_next = ERR_NONE;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        if (op_is_legal(desc_op)) begin
          state_next = S_SWITCH;
        end else begin
          state_next    = S_ERR;
          err_code_next = ERR_OPCODE;
        end
      end
      S_SWITCH: state_next = S_RUN;
      // Completion wins over a watchdog expiry in the same cycle
      S_RUN: begin
        if (bus.unit_done) begin
          state_next = S_GAP;
        end else if (wdog_expire) begin
          state_next    = S_ERR;
          err_code_next = ERR_WDOG;
        end
      end
      S_GAP: begin
        if (last_reg) begin
          state_next = S_DONE;
        end else if (idx_reg == IDX_LAST) begin
          state_next    = S_ERR;
          err_code_next = ERR_LIMIT;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_DONE:   state_next = S_IDLE;
      S_ERR:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= S_IDLE;
      base_reg       <= '0;
      idx_reg        <= '0;
      last_reg       <= 1'b0;
      mode_reg       <= IDLE_MODE;
      unit_start_reg <= 1'b0;
      err_reg        <= 1'b0;
      err_code_reg   <= ERR_NONE;
    end else begin
      state_reg      <= state_next;
      unit_start_reg <= (state_reg == S_SWITCH);

      if ((state_reg == S_IDLE) && start) begin
        base_reg     <= base_addr;
        idx_reg      <= '0;
        err_reg      <= 1'b0;
        err_code_reg <= ERR_NONE;
      end

      if (state_reg == S_DECODE) begin
        last_reg <= bus.desc_R_data[DESC_LAST_BIT];
      end

      // Mode only moves on SWITCH entry (operator) and GAP/ERR entry (idle)
      if ((state_reg == S_DECODE) && (state_next == S_SWITCH)) begin
        mode_reg <= desc_op;
      end else if ((state_next == S_GAP) || (state_next == S_ERR)) begin
        mode_reg <= IDLE_MODE;
      end

      if ((state_reg == S_GAP) && (state_next == S_FETCH)) begin
        idx_reg <= idx_reg + 1'b1;
      end

      if ((state_next == S_ERR) && (state_reg != S_ERR)) begin
        err_reg      <= 1'b1;
        err_code_reg <= err_code_next;
      end
    end
  end

  assign bus.desc_cs    = (state_reg == S_FETCH);
  assign bus.desc_oe    = (state_reg == S_FETCH);
  assign bus.desc_addr  = (state_reg == S_FETCH) ? (base_reg + ADDR_W'(idx_reg)) : '0;
  assign bus.mode       = mode_reg;
  assign bus.unit_start = unit_start_reg;

  assign busy      = (state_reg != S_IDLE);
  assign done      = (state_reg == S_DONE);
  assign err       = err_reg;
  assign err_code  = err_code_reg;
  assign layer_idx = idx_reg;

endmodule

// File: tb/tb_epu_layer_sequencer.sv
// Directed bench: instance A (4-layer limit) covers sequencing, errors and reset;
// instance B (4-bit watchdog) covers the run timeout.
module tb_epu_layer_sequencer;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        start_a, start_b;
  logic [15:0] base_a, base_b;
  logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [1:0]  err_code_a, err_code_b;
  logic [1:0]  layer_idx_a;
  logic [5:0]  layer_idx_b;

  epu_layer_sequencer_if #(.ADDR_W(16)) if_a ();
  epu_layer_sequencer_if #(.ADDR_W(16)) if_b ();

  epu_layer_sequencer #(.ADDR_W(16), .MAX_LAYERS(4), .WDOG_W(8)) u_dut_a (
    .clk(clk), .rstn(rstn), .start(start_a), .base_addr(base_a), .bus(if_a),
    .busy(busy_a), .done(done_a), .err(err_a), .err_code(err_code_a), .layer_idx(layer_idx_a)
  );

  epu_layer_sequencer #(.ADDR_W(16), .MAX_LAYERS(64), .WDOG_W(4)) u_dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .base_addr(base_b), .bus(if_b),
    .busy(busy_b), .done(done_b), .err(err_b), .err_code(err_code_b), .layer_idx(layer_idx_b)
  );

  logic [31:0] mem [256];

  always @(posedge clk) begin
    if (if_a.desc_cs && if_a.desc_oe) if_a.desc_R_data <= mem[if_a.desc_addr[7:0]];
    if (if_b.desc_cs && if_b.desc_oe) if_b.desc_R_data <= mem[if_b.desc_addr[7:0]];
  end

  int vectors = 0;
  int miscompares = 0;

  // Monitor for instance A, sampled well after the falling edge
  int          ustart_cnt, done_cnt;
  logic [15:0] fetch_q[$];
  logic [3:0]  mode_q[$];
  logic [3:0]  last_mode = 4'd0;

  always @(negedge clk) begin
    #2;
    if (if_a.unit_start) ustart_cnt++;
    if (done_a) done_cnt++;
    if (if_a.desc_cs) fetch_q.push_back(if_a.desc_addr);
    if (if_a.mode !== last_mode) begin
      mode_q.push_back(if_a.mode);
      last_mode = if_a.mode;
    end
  end

  task automatic clear_mon();
    @(negedge clk);
    ustart_cnt = 0;
    done_cnt   = 0;
    fetch_q.delete();
    mode_q.delete();
    last_mode  = if_a.mode;
  endtask

  task automatic start_run_a(input logic [15:0] base);
    @(negedge clk); start_a = 1'b1; base_a = base;
    @(negedge clk); start_a = 1'b0; base_a = 16'h0;
  endtask

  task automatic wait_ustart_a(input string tag);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (if_a.unit_start) return;
    end
    vectors++; miscompares++;
    $display("FAIL %s_ustart_timeout: unit_start not seen within 60 cycles, required 1", tag);
  endtask

  task automatic wait_idle_a(input string tag);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy_a) return;
    end
    vectors++; miscompares++;
    $display("FAIL %s_idle_timeout: busy still %0b after 60 cycles, required 0", tag, busy_a);
  endtask

  task automatic pulse_done_a();
    if_a.unit_done = 1'b1;
    @(negedge clk);
    if_a.unit_done = 1'b0;
  endtask

  task automatic check_fetches(input string tag, input logic [15:0] base, input int n);
    logic [15:0] got;
    vectors++;
    if (fetch_q.size() != n) begin
      miscompares++;
      $display("FAIL %s_fetch_count: got %0d required %0d", tag, fetch_q.size(), n);
    end
    for (int i = 0; i < n; i++) begin
      got = (i < fetch_q.size()) ? fetch_q[i] : 16'hxxxx;
      vectors++;
      if (got !== 16'(base + 16'(i))) begin
        miscompares++;
        $display("FAIL %s_fetch_addr%0d: got %0h required %0h", tag, i, got, base + 16'(i));
      end
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({busy_a, done_a, err_a, err_code_a, layer_idx_a, if_a.mode, if_a.unit_start,
         if_a.desc_cs, if_a.desc_oe, if_a.desc_addr} !== 31'h0) begin
      miscompares++;
      $display("FAIL reset_outputs_a: busy=%0b done=%0b err=%0b code=%0d idx=%0d mode=%0h cs=%0b addr=%0h required all 0",
               busy_a, done_a, err_a, err_code_a, layer_idx_a, if_a.mode, if_a.desc_cs, if_a.desc_addr);
    end
    vectors++;
    if ({busy_b, done_b, err_b, err_code_b, layer_idx_b, if_b.mode, if_b.unit_start} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_outputs_b: busy=%0b err=%0b code=%0d idx=%0d mode=%0h required all 0",
               busy_b, err_b, err_code_b, layer_idx_b, if_b.mode);
    end
  endtask

  task automatic test_single_layer();
    clear_mon();
    mem[8'h10] = 32'h8000_0001;
    @(negedge clk); start_a = 1'b1; base_a = 16'h0010;            // cycle 0
    @(negedge clk); start_a = 1'b0; base_a = 16'h0;               // cycle 1: FETCH
    vectors++;
    if (if_a.desc_cs !== 1'b1 || if_a.desc_oe !== 1'b1 || if_a.desc_addr !== 16'h0010) begin
      miscompares++;
      $display("FAIL single_fetch: cs=%0b oe=%0b addr=%0h required 1 1 10", if_a.desc_cs, if_a.desc_oe, if_a.desc_addr);
    end
    if_a.unit_done = 1'b1;                                        // stray done outside RUN
    @(negedge clk); if_a.unit_done = 1'b0;                        // cycle 2: DECODE
    @(negedge clk);                                               // cycle 3: SWITCH
    vectors++;
    if (if_a.mode !== 4'd1 || if_a.unit_start !== 1'b0) begin
      miscompares++;
      $display("FAIL single_switch: mode=%0h unit_start=%0b required 1 0", if_a.mode, if_a.unit_start);
    end
    @(negedge clk);                                               // cycle 4: first RUN
    vectors++;
    if (if_a.unit_start !== 1'b1) begin
      miscompares++;
      $display("FAIL single_unit_start: got %0b required 1", if_a.unit_start);
    end
    repeat (16) @(negedge clk);                                   // cycle 20
    vectors++;
    if (if_a.mode !== 4'd1 || busy_a !== 1'b1 || if_a.unit_start !== 1'b0) begin
      miscompares++;
      $display("FAIL single_run_hold: mode=%0h busy=%0b unit_start=%0b required 1 1 0", if_a.mode, busy_a, if_a.unit_start);
    end
    pulse_done_a();                                               // cycle 21: GAP
    vectors++;
    if (if_a.mode !== 4'd0 || done_a !== 1'b0) begin
      miscompares++;
      $display("FAIL single_gap: mode=%0h done=%0b required 0 0", if_a.mode, done_a);
    end
    @(negedge clk);                                               // cycle 22: DONE
    vectors++;
    if (done_a !== 1'b1 || busy_a !== 1'b1) begin
      miscompares++;
      $display("FAIL single_done_pulse: done=%0b busy=%0b required 1 1", done_a, busy_a);
    end
    @(negedge clk);                                               // cycle 23: IDLE
    vectors++;
    if (done_a !== 1'b0 || busy_a !== 1'b0 || layer_idx_a !== 2'd0 || err_a !== 1'b0) begin
      miscompares++;
      $display("FAIL single_end: done=%0b busy=%0b idx=%0d err=%0b required 0 0 0 0", done_a, busy_a, layer_idx_a, err_a);
    end
    @(negedge clk);
    vectors++;
    if (ustart_cnt !== 1 || done_cnt !== 1) begin
      miscompares++;
      $display("FAIL single_counts: unit_starts=%0d dones=%0d required 1 1", ustart_cnt, done_cnt);
    end
  endtask

  task automatic test_three_layers();
    logic [3:0] exp_modes [6];
    exp_modes = '{4'd2, 4'd0, 4'd1, 4'd0, 4'd3, 4'd0};
    clear_mon();
    mem[8'h20] = 32'h0000_0002;
    mem[8'h21] = 32'h0000_0001;
    mem[8'h22] = 32'h8000_0003;
    start_run_a(16'h0020);
    for (int l = 0; l < 3; l++) begin
      wait_ustart_a("three");
      if (l == 0) begin
        start_a = 1'b1; base_a = 16'h0099;                        // must be ignored while busy
        @(negedge clk);
        start_a = 1'b0; base_a = 16'h0;
      end
      repeat (2) @(negedge clk);
      if (l == 2) begin
        vectors++;
        if (done_cnt !== 0) begin
          miscompares++;
          $display("FAIL three_early_done: got %0d done pulses before last unit_done, required 0", done_cnt);
        end
      end
      pulse_done_a();
    end
    wait_idle_a("three");
    @(negedge clk);
    check_fetches("three", 16'h0020, 3);
    vectors++;
    if (mode_q.size() != 6) begin
      miscompares++;
      $display("FAIL three_mode_count: got %0d mode changes required 6", mode_q.size());
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (i >= mode_q.size() || mode_q[i] !== exp_modes[i]) begin
        miscompares++;
        $display("FAIL three_mode_seq%0d: got %0h required %0h", i, (i < mode_q.size()) ? mode_q[i] : 4'hx, exp_modes[i]);
      end
    end
    vectors++;
    if (ustart_cnt !== 3 || done_cnt !== 1 || err_a !== 1'b0 || layer_idx_a !== 2'd2) begin
      miscompares++;
      $display("FAIL three_end: unit_starts=%0d dones=%0d err=%0b idx=%0d required 3 1 0 2", ustart_cnt, done_cnt, err_a, layer_idx_a);
    end
  endtask

  task automatic test_illegal_opcode();
    clear_mon();
    mem[8'h30] = 32'h0000_0002;
    mem[8'h31] = 32'h0000_000F;
    start_run_a(16'h0030);
    wait_ustart_a("illegal");
    @(negedge clk);
    pulse_done_a();
    wait_idle_a("illegal");
    @(negedge clk);
    vectors++;
    if (err_a !== 1'b1 || err_code_a !== 2'd1 || if_a.mode !== 4'd0) begin
      miscompares++;
      $display("FAIL illegal_err: err=%0b code=%0d mode=%0h required 1 1 0", err_a, err_code_a, if_a.mode);
    end
    vectors++;
    if (ustart_cnt !== 1 || done_cnt !== 0 || layer_idx_a !== 2'd1 || mode_q.size() != 2) begin
      miscompares++;
      $display("FAIL illegal_counts: unit_starts=%0d dones=%0d idx=%0d mode_changes=%0d required 1 0 1 2",
               ustart_cnt, done_cnt, layer_idx_a, mode_q.size());
    end
  endtask

  task automatic test_watchdog();
    mem[8'h40] = 32'h0000_0001;
    @(negedge clk); start_b = 1'b1; base_b = 16'h0040;            // cycle 0
    @(negedge clk); start_b = 1'b0; base_b = 16'h0;               // cycle 1
    repeat (3) @(negedge clk);                                    // cycle 4: first RUN
    vectors++;
    if (if_b.unit_start !== 1'b1 || if_b.mode !== 4'd1) begin
      miscompares++;
      $display("FAIL wdog_run_entry: unit_start=%0b mode=%0h required 1 1", if_b.unit_start, if_b.mode);
    end
    repeat (14) @(negedge clk);                                   // cycle 18: 15th RUN cycle
    vectors++;
    if (err_b !== 1'b0 || if_b.mode !== 4'd1 || busy_b !== 1'b1) begin
      miscompares++;
      $display("FAIL wdog_before: err=%0b mode=%0h busy=%0b required 0 1 1", err_b, if_b.mode, busy_b);
    end
    @(negedge clk);                                               // cycle 19: ERR
    vectors++;
    if (err_b !== 1'b1 || err_code_b !== 2'd2 || if_b.mode !== 4'd0 || busy_b !== 1'b1 || done_b !== 1'b0) begin
      miscompares++;
      $display("FAIL wdog_expire: err=%0b code=%0d mode=%0h busy=%0b done=%0b required 1 2 0 1 0",
               err_b, err_code_b, if_b.mode, busy_b, done_b);
    end
    @(negedge clk);                                               // cycle 20: IDLE
    vectors++;
    if (busy_b !== 1'b0 || err_b !== 1'b1 || err_code_b !== 2'd2) begin
      miscompares++;
      $display("FAIL wdog_idle: busy=%0b err=%0b code=%0d required 0 1 2", busy_b, err_b, err_code_b);
    end
  endtask

  task automatic test_layer_limit();
    clear_mon();
    for (int i = 0; i < 4; i++) mem[8'h50 + i] = 32'h0000_0003;
    start_run_a(16'h0050);
    for (int l = 0; l < 4; l++) begin
      wait_ustart_a("limit");
      pulse_done_a();                                             // done coincident with unit_start
    end
    wait_idle_a("limit");
    @(negedge clk);
    check_fetches("limit", 16'h0050, 4);
    vectors++;
    if (err_a !== 1'b1 || err_code_a !== 2'd3 || if_a.mode !== 4'd0) begin
      miscompares++;
      $display("FAIL limit_err: err=%0b code=%0d mode=%0h required 1 3 0", err_a, err_code_a, if_a.mode);
    end
    vectors++;
    if (ustart_cnt !== 4 || done_cnt !== 0 || layer_idx_a !== 2'd3) begin
      miscompares++;
      $display("FAIL limit_counts: unit_starts=%0d dones=%0d idx=%0d required 4 0 3", ustart_cnt, done_cnt, layer_idx_a);
    end
  endtask

  task automatic test_reset_mid_run();
    clear_mon();
    start_run_a(16'h0010);
    wait_ustart_a("midrst");
    @(negedge clk);
    rstn = 1'b0;
    #1;
    vectors++;
    if ({busy_a, done_a, err_a, err_code_a, layer_idx_a, if_a.mode, if_a.unit_start, if_a.desc_cs} !== 12'h0) begin
      miscompares++;
      $display("FAIL midrst_outputs: busy=%0b done=%0b err=%0b code=%0d idx=%0d mode=%0h ustart=%0b required all 0",
               busy_a, done_a, err_a, err_code_a, layer_idx_a, if_a.mode, if_a.unit_start);
    end
    vectors++;
    if (err_b !== 1'b0 || err_code_b !== 2'd0) begin
      miscompares++;
      $display("FAIL midrst_sticky_clear: err=%0b code=%0d required 0 0", err_b, err_code_b);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (done_cnt !== 0 || busy_a !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_no_done: dones=%0d busy=%0b required 0 0", done_cnt, busy_a);
    end
    clear_mon();
    start_run_a(16'h0010);
    wait_ustart_a("restart");
    repeat (3) @(negedge clk);
    pulse_done_a();
    wait_idle_a("restart");
    @(negedge clk);
    vectors++;
    if (done_cnt !== 1 || ustart_cnt !== 1 || err_a !== 1'b0 || mode_q.size() != 2) begin
      miscompares++;
      $display("FAIL restart_run: dones=%0d unit_starts=%0d err=%0b mode_changes=%0d required 1 1 0 2",
               done_cnt, ustart_cnt, err_a, mode_q.size());
    end
  endtask

  initial begin
    rstn = 1'b0;
    start_a = 1'b0; base_a = 16'h0; start_b = 1'b0; base_b = 16'h0;
    if_a.unit_done = 1'b0; if_b.unit_done = 1'b0;
    if_a.desc_R_data = 32'h0; if_b.desc_R_data = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    test_reset();
    rstn = 1'b1;
    @(negedge clk);
    test_single_layer();
    test_three_layers();
    test_illegal_opcode();
    test_watchdog();
    test_layer_limit();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
